countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Programmable down-counting timer; complement to the up-counting event counter.
//   Loads a start value, decrements once per PRESCALE enabled clocks and pulses
//   expired_o on reaching zero. Used for timeouts and periodic ticks in this design.
// PARAMETERS
//   WIDTH     8  width of load_value_i and count_o
//   PRESCALE  8  enabled clocks per decrement; legal range >= 1
// PORTS
//   clock_i       input   1      system clock; all state changes on posedge
//   reset_i       input   1      synchronous, active-high reset
//   enable_i      input   1      count qualifier; low freezes all counting state
//   load_i        input   1      single-cycle request to load load_value_i and start
//   load_value_i  input   WIDTH  start value, sampled when load_i=1
//   count_o       output  WIDTH  current remaining count (registered)
//   busy_o        output  1      1 while the timer is in RUN
//   expired_o     output  1      one-cycle pulse when count reaches zero
// BEHAVIOUR
// - Reset (sync, active-high, highest priority) clears all state:
//   count_o=0, busy_o=0, expired_o=0, prescale counter=0, state=IDLE,
//   and reload register=0. Applies mid-run. No expired_o pulse.
// - States: IDLE (busy_o=0) and RUN (busy_o=1). busy_o is a pure decode of state.
// - Prescale counter width is max(1, $clog2(PRESCALE)).
// - load_i=1 (priority over counting, in any state, independent of enable_i):
//   - count_o<=load_value_i and prescale<=0. A pending decrement in that cycle is discarded.
//   - Nonzero value: state<=RUN, expired_o<=0.
//   - Zero value: state<=IDLE, expired_o<=1 for exactly the next cycle.
// - RUN, load_i=0, enable_i=1:
//   - Prescale counter increments.
//   - When prescale==PRESCALE-1, it wraps to 0 and count_o<=count_o-1.
//   - If that decrement takes count_o from 1 to 0, expiry fires:
//     state<=IDLE and expired_o<=1 on the same edge that count_o becomes 0.
// - RUN, enable_i=0: count_o and prescale hold. Partial prescale progress is kept.
// - IDLE: enable_i ignored; count_o holds its value, never wraps below 0.
// - expired_o is 0 on every cycle except the single cycle after an expiry edge.
// - Timing: with enable_i held high, load N>0 at edge 0 gives:
//   count_o=N-k after edge k*PRESCALE, and expired_o high after edge N*PRESCALE.
// - count_o arithmetic is modulo 2^WIDTH but never underflows; the zero check precedes the decrement.
// CONFIGURATION
// - Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
// - Defined:
//   - A nonzero load also stores load_value_i in the reload register.
//   - On expiry, count_o<=reload register (not 0), state stays RUN, busy_o stays 1,
//     and expired_o pulses once per period of N*PRESCALE enabled clocks.
//   - A zero load clears the reload register and behaves as in the base design.
// - Undefined: no reload register; the timer stops in IDLE after expiry.
// TESTING
// 1. Assert reset_i 2 cycles with load_i=1 -> count_o=0, busy_o=0, expired_o=0 after reset.
// 2. PRESCALE=8, load 3, enable_i=1 -> count_o 3/2/1/0 after edges 0/8/16/24;
//    expired_o high only in the cycle after edge 24; busy_o falls with it.
// 3. Load 3 with enable_i toggling 1,0,1,0 -> expiry after edge 48; values hold while enable_i=0.
// 4. Load 5, then at count_o=2 with prescale=5 load 7 -> count_o=7, prescale=0,
//    no expired_o, next decrement 8 enabled clocks later.
// 5. Load 0 -> expired_o=1 for exactly one cycle, busy_o=0, count_o=0.
// 6. AUTO_RELOAD_EN, PRESCALE=8, load 2 -> expired_o every 16 cycles, count_o=2 after each;
//    reset_i mid-period -> IDLE, count_o=0, no further pulses.

Source files
------------

// File: rtl/countdown_timer.sv
// Programmable down-counting timer: load a start value, decrement once every PRESCALE
// enabled clocks, pulse expired_o for one cycle when the count reaches zero.
// Optional build macro COUNTDOWN_TIMER_AUTO_RELOAD_EN: on expiry reload the last nonzero
// start value and keep running instead of stopping in IDLE.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             expired_o
);

  // A PRESCALE of 1 still needs a one-bit prescale counter that simply stays at zero.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             expired_q, expired_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state logic: a load overrides everything, otherwise count only while running and enabled.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ps_d      = ps_q;
    expired_d = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (load_i) begin
      count_d = load_value_i;
      ps_d    = '0;
      if (load_value_i != '0) begin
        state_d = ST_RUN;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_d = load_value_i;
`endif
      end else begin
        state_d   = ST_IDLE;
        expired_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_d  = '0;
`endif
      end
    end else if (state_q == ST_RUN && enable_i) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        // Zero check precedes the decrement so the count can never wrap below zero.
        if (count_q == WIDTH'(1)) begin
          expired_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          count_d   = reload_q;
`else
          count_d   = '0;
          state_d   = ST_IDLE;
`endif
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ps_q      <= '0;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ps_q      <= ps_d;
      expired_q <= expired_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count_o   = count_q;
  assign busy_o    = (state_q == ST_RUN);
  assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with WIDTH=8, PRESCALE=8.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
// Edge numbering in each scenario counts from the edge that samples the load.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] load_value_i = 8'd0;
  logic [7:0] count_o;
  logic       busy_o;
  logic       expired_o;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  countdown_timer #(.WIDTH(8), .PRESCALE(8)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .expired_o    (expired_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge (edge 0 of a scenario).
  task automatic do_load(input logic [7:0] v);
    load_value_i = v;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    // 1: reset dominates a simultaneous load
    reset_i = 1'b1; load_i = 1'b1; load_value_i = 8'd9; enable_i = 1'b1;
    step(); step();
    reset_i = 1'b0; load_i = 1'b0;
    check("rst_count", count_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_expired", expired_o, 0);

    // 2: load 3, enable held high
    do_load(8'd3);
    check("t2_e0_count", count_o, 3);
    check("t2_e0_busy", busy_o, 1);
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (expired_o) pulses++;
      if (k == 7)  check("t2_e7_count", count_o, 3);
      if (k == 8)  check("t2_e8_count", count_o, 2);
      if (k == 16) check("t2_e16_count", count_o, 1);
      if (k == 23) check("t2_e23_expired", expired_o, 0);
      if (k == 24) begin
        check("t2_e24_count", count_o, 0);
        check("t2_e24_expired", expired_o, 1);
        check("t2_e24_busy", busy_o, 0);
      end
      if (k == 25) check("t2_e25_expired", expired_o, 0);
    end
    check("t2_pulses", pulses, 1);
    check("t2_idle_count", count_o, 0);

    // 3: enable alternates, high on even edges -> 24 enabled clocks by edge 48
    do_load(8'd3);
    pulses = 0;
    for (int k = 1; k <= 52; k++) begin
      enable_i = (k % 2 == 0);
      step();
      if (expired_o) pulses++;
      if (k == 16) check("t3_e16_count", count_o, 2);
      if (k == 17) check("t3_e17_hold", count_o, 2);
      if (k == 47) begin
        check("t3_e47_count", count_o, 1);
        check("t3_e47_expired", expired_o, 0);
      end
      if (k == 48) begin
        check("t3_e48_count", count_o, 0);
        check("t3_e48_expired", expired_o, 1);
      end
    end
    check("t3_pulses", pulses, 1);
    enable_i = 1'b1;

    // 4: reload mid-run at count 2, prescale 5 (edge 29), load 7 at edge 30
    do_load(8'd5);
    pulses = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (expired_o) pulses++;
    end
    check("t4_e29_count", count_o, 2);
    do_load(8'd7);
    check("t4_reload_count", count_o, 7);
    check("t4_reload_expired", expired_o, 0);
    check("t4_reload_busy", busy_o, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (expired_o) pulses++;
      if (k == 7) check("t4_p7_count", count_o, 7);
      if (k == 8) check("t4_p8_count", count_o, 6);
    end
    check("t4_pulses", pulses, 0);

    // 4b: load in the cycle a decrement was due discards that decrement
    do_load(8'd4);
    for (int k = 1; k <= 7; k++) step();
    do_load(8'd4);
    check("t4b_discard_count", count_o, 4);
    step();
    check("t4b_next_count", count_o, 4);

    // 5: zero load while running
    do_load(8'd0);
    check("t5_expired", expired_o, 1);
    check("t5_busy", busy_o, 0);
    check("t5_count", count_o, 0);
    step();
    check("t5_expired_drop", expired_o, 0);
    for (int k = 0; k < 10; k++) step();
    check("t5_nowrap_count", count_o, 0);
    check("t5_idle_busy", busy_o, 0);

    // 6: expiry behaviour, then reset mid-period
    do_load(8'd2);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (expired_o) pulses++;
      if (k == 16) begin
        check("t6_e16_expired", expired_o, 1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        check("t6_e16_count", count_o, 2);
        check("t6_e16_busy", busy_o, 1);
`else
        check("t6_e16_count", count_o, 0);
        check("t6_e16_busy", busy_o, 0);
`endif
      end
      if (k == 17) check("t6_e17_expired", expired_o, 0);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      if (k == 32) begin
        check("t6_e32_expired", expired_o, 1);
        check("t6_e32_count", count_o, 2);
      end
`endif
    end
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    check("t6_pulses", pulses, 2);
`else
    check("t6_pulses", pulses, 1);
`endif
    // Mid-run reset: start a fresh run, reset partway through
    do_load(8'd5);
    for (int k = 0; k < 12; k++) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("t6_rst_count", count_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_expired", expired_o, 0);
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (expired_o) pulses++;
    end
    check("t6_rst_pulses", pulses, 0);
    check("t6_rst_final_count", count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
